// File: rtl/multicycle_control.sv
// Control FSM for a multi-cycle MIPS datapath (R-format, lw, sw, beq, addi, j).
// Moore-style decode of the state register, with mem_ready qualifying the FETCH and MEM_WR strobes.
module multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] instr_op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       alu_src_a,
  output logic       reg_write,
  output logic       reg_dst,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_d;
  logic   op_supported;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    op_supported = 1'b0;
    case (instr_op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_supported = 1'b1;
      default:                                       op_supported = 1'b0;
    endcase
  end

  // Next-state logic; instr_op is only consulted in DECODE and MEM_ADDR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (instr_op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: begin
        // Only lw/sw reach here; anything else falls back to FETCH harmlessly.
        if (instr_op == OP_LW) begin
          state_d = S_MEM_RD;
        end else if (instr_op == OP_SW) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_RD:    state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WR:    state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:    state_d = S_R_WB;
      S_R_WB:      state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JUMP:      state_d = S_FETCH;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_ADDI_WB:   state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_d.mem_read  = 1'b1;
        ctrl_d.alu_src_b = SRCB_FOUR;
        ctrl_d.alu_op    = ALU_ADD;
        ctrl_d.pc_source = PCSRC_ALU;
        ctrl_d.ir_write  = mem_ready;
        ctrl_d.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the opcode is decoded.
        ctrl_d.alu_src_b  = SRCB_IMMSH;
        ctrl_d.alu_op     = ALU_ADD;
        ctrl_d.illegal_op = ~op_supported;
      end
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_d.mem_write  = 1'b1;
        ctrl_d.i_or_d     = 1'b1;
        ctrl_d.instr_done = mem_ready;
      end
      S_R_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_REG;
        ctrl_d.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.reg_dst    = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_src_b     = SRCB_REG;
        ctrl_d.alu_op        = ALU_SUB;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = PCSRC_ALUOUT;
        ctrl_d.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl_d.pc_write   = 1'b1;
        ctrl_d.pc_source  = PCSRC_JUMP;
        ctrl_d.instr_done = 1'b1;
      end
      S_ADDI_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = SRCB_IMM;
        ctrl_d.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.instr_done = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // Reset masks every output so no write can fire while the FSM is being restarted.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    alu_src_a     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_op        = 2'b00;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    state         = 4'd0;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    if (!rst) begin
      pc_write      = ctrl_d.pc_write;
      pc_write_cond = ctrl_d.pc_write_cond;
      i_or_d        = ctrl_d.i_or_d;
      mem_read      = ctrl_d.mem_read;
      mem_write     = ctrl_d.mem_write;
      mem_to_reg    = ctrl_d.mem_to_reg;
      ir_write      = ctrl_d.ir_write;
      alu_src_a     = ctrl_d.alu_src_a;
      reg_write     = ctrl_d.reg_write;
      reg_dst       = ctrl_d.reg_dst;
      alu_op        = ctrl_d.alu_op;
      alu_src_b     = ctrl_d.alu_src_b;
      pc_source     = ctrl_d.pc_source;
      state         = state_q;
      instr_done    = ctrl_d.instr_done;
      illegal_op    = ctrl_d.illegal_op;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-cycle vector table through a scoreboard queue,
// plus hand-driven lw sequences with random memory wait states.
module tb_multicycle_control;

  logic       clk;
  logic       rst;
  logic [5:0] instr_op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst;
  logic [1:0] alu_op, alu_src_b, pc_source;
  logic [3:0] state;
  logic       instr_done, illegal_op;

  multicycle_control dut (
    .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .alu_src_a(alu_src_a), .reg_write(reg_write),
    .reg_dst(reg_dst), .alu_op(alu_op), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .state(state), .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [21:0] got;
  assign got = {state, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst,
                alu_op, alu_src_b, pc_source, instr_done, illegal_op};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        rdy;
    logic [21:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [21:0] sb_q[$];
  int          checks = 0;
  int          passes = 0;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

  function automatic logic [21:0] mk(input logic [3:0] st, input logic pcw, input logic pcwc,
                                     input logic iord, input logic mrd, input logic mwr,
                                     input logic m2r, input logic irw, input logic asa,
                                     input logic rw, input logic rd, input logic [1:0] aop,
                                     input logic [1:0] asb, input logic [1:0] pcs,
                                     input logic done, input logic ill);
    return {st, pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, aop, asb, pcs, done, ill};
  endfunction

  logic [21:0] E_RST, F_W, F_R, DEC, DEC_ILL, MA, MR, MWB, MW_W, MW_R, RE, RWB, BR, JP, AE, AWB;

  task automatic add(input logic r, input logic [5:0] op, input logic rdy, input logic [21:0] e);
    vec_t v;
    v.rst = r; v.op = op; v.rdy = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s #%0d: got %h expected %h", name, idx, act, req);
  endtask

  int fw, dw, cycles, fcnt, dcnt, pcw_cnt, irw_cnt, done_cnt;
  bit finished;

  initial begin
    E_RST   = '0;
    //           st    pcw pcwc iord mrd mwr m2r irw asa rw rd aop    asb    pcs    done ill
    F_W     = mk(4'd0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0);
    F_R     = mk(4'd0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 2'b00, 2'b01, 2'b00, 0, 0);
    DEC     = mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 0);
    DEC_ILL = mk(4'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 2'b00, 0, 1);
    MA      = mk(4'd2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 0, 0);
    MR      = mk(4'd3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    MWB     = mk(4'd4, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    MW_W    = mk(4'd5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0);
    MW_R    = mk(4'd5, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0);
    RE      = mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 0, 0);
    RWB     = mk(4'd7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 1, 0);
    BR      = mk(4'd8, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 2'b00, 2'b01, 1, 0);
    JP      = mk(4'd9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 1, 0);
    AE      = mk(4'd10, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b00, 0, 0);
    AWB     = mk(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1, 0);

    // Reset, then R-format
    add(1, R, 1, E_RST); add(1, R, 1, E_RST);
    add(0, R, 1, F_R); add(0, R, 1, DEC); add(0, R, 1, RE); add(0, R, 1, RWB);
    // lw with two data-read wait cycles
    add(0, LW, 1, F_R); add(0, LW, 1, DEC); add(0, LW, 1, MA);
    add(0, LW, 0, MR); add(0, LW, 0, MR); add(0, LW, 1, MR); add(0, LW, 1, MWB);
    // sw then beq back-to-back
    add(0, SW, 1, F_R); add(0, SW, 1, DEC); add(0, SW, 1, MA); add(0, SW, 1, MW_R);
    add(0, BEQ, 1, F_R); add(0, BEQ, 1, DEC); add(0, BEQ, 1, BR);
    // Fetch wait states, then j
    add(0, J, 0, F_W); add(0, J, 0, F_W); add(0, J, 0, F_W);
    add(0, J, 1, F_R); add(0, J, 1, DEC); add(0, J, 1, JP);
    // addi, with mem_ready low where it must be ignored
    add(0, ADDI, 1, F_R); add(0, ADDI, 0, DEC); add(0, ADDI, 0, AE); add(0, ADDI, 0, AWB);
    // Illegal opcode: two cycles, no retire, no writes
    add(0, BAD, 1, F_R); add(0, BAD, 1, DEC_ILL);
    // sw with a write wait state
    add(0, SW, 1, F_R); add(0, SW, 1, DEC); add(0, SW, 1, MA);
    add(0, SW, 0, MW_W); add(0, SW, 1, MW_R);
    // Reset while in R_EXEC
    add(0, R, 1, F_R); add(0, R, 1, DEC); add(0, R, 1, RE);
    add(1, R, 1, E_RST); add(0, R, 1, F_R); add(0, R, 1, DEC);
    // Reset during a waiting data read drops the access
    add(0, LW, 1, RE); add(0, LW, 1, RWB);
    add(0, LW, 1, F_R); add(0, LW, 1, DEC); add(0, LW, 1, MA); add(0, LW, 0, MR);
    add(1, LW, 0, E_RST); add(1, LW, 1, E_RST); add(0, LW, 0, F_W);

    rst = 1'b1; instr_op = R; mem_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      rst = vecs[i].rst; instr_op = vecs[i].op; mem_ready = vecs[i].rdy;
      sb_q.push_back(vecs[i].exp);
      @(negedge clk);
      check("vec", i, {10'd0, got}, {10'd0, sb_q.pop_front()});
      $display("vec %0d: rst=%0b op=%b rdy=%0b state=%0d out=%h", i, rst, instr_op, mem_ready, state, got);
    end

    // Finish the FETCH left waiting by the last vector, then run lw with random waits.
    @(posedge clk); #1; mem_ready = 1'b1; instr_op = R;
    @(posedge clk); #1;
    while (state != 4'd0) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      fw = $urandom_range(0, 3); dw = $urandom_range(0, 3);
      cycles = 0; fcnt = 0; dcnt = 0; pcw_cnt = 0; irw_cnt = 0; done_cnt = 0; finished = 0;
      instr_op = LW;
      while (!finished && cycles < 40) begin
        if (state == 4'd0) begin mem_ready = (fcnt >= fw); fcnt++; end
        else if (state == 4'd3) begin mem_ready = (dcnt >= dw); dcnt++; end
        else mem_ready = 1'b0;
        @(negedge clk);
        cycles++;
        pcw_cnt  += int'(pc_write);
        irw_cnt  += int'(ir_write);
        done_cnt += int'(instr_done);
        if (instr_done) finished = 1;
        @(posedge clk); #1;
      end
      check("lw_cycles", k, cycles, 5 + fw + dw);
      check("lw_pc_write_pulses", k, pcw_cnt, 1);
      check("lw_ir_write_pulses", k, irw_cnt, 1);
      check("lw_done_pulses", k, done_cnt, 1);
      check("lw_back_to_fetch", k, {28'd0, state}, 0);
      $display("lw seq %0d: fetch_waits=%0d data_waits=%0d cycles=%0d", k, fw, dw, cycles);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
